wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the register file's single write port between two write-back requesters:
//  ALU results (dest = rd) and memory loads (dest = rt).
//  Each requester has a valid/ready handshake and a private FIFO.
//  A round-robin (or fixed-priority) arbiter pops one entry per cycle into a registered write port.
//  Sits between the execute/memory stages and the register file, replacing the static write-register select.
// PARAMETERS
//  DATA_W      32  write-data width
//  ADDR_W      5   register address width
//  FIFO_DEPTH  2   entries per requester FIFO; power of 2, >= 2
//  RR_EN       1   1 = round-robin; 0 = fixed priority, ALU port always wins
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous reset, active low
//  alu_valid   in   1       ALU write-back request
//  alu_ready   out  1       ALU FIFO can accept
//  alu_reg     in   ADDR_W  ALU destination register (rd)
//  alu_data    in   DATA_W  ALU result
//  mem_valid   in   1       load write-back request
//  mem_ready   out  1       load FIFO can accept
//  mem_reg     in   ADDR_W  load destination register (rt)
//  mem_data    in   DATA_W  load data
//  reg_write   out  1       register file write enable
//  write_reg   out  ADDR_W  register file write address
//  write_data  out  DATA_W  register file write data
//  last_grant  out  1       0 = ALU granted last, 1 = MEM granted last
//  busy        out  1       any FIFO non-empty or reg_write high
// BEHAVIOUR
//  Reset (rst_n low, asynchronous):
//   - FIFOs emptied; pointers and counts = 0.
//   - reg_write/write_reg/write_data = 0; last_grant = 1, so the ALU wins the first tie.
//   - alu_ready/mem_ready forced 0 while rst_n is low.
//   - Reset mid-operation discards all queued entries; no write issues after release.
//  Push:
//   - x_ready = !full(x), computed from the count before this cycle's pop.
//   - A full FIFO refuses a push even if it pops in the same cycle.
//   - Accept when x_valid && x_ready; {reg,data} is captured at the tail.
//   - Pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH.
//  Arbitrate (each cycle, combinational on FIFO state):
//   - Only one FIFO non-empty: that FIFO is granted.
//   - Both non-empty, RR_EN=1: grant the port != last_grant.
//   - Both non-empty, RR_EN=0: grant the ALU.
//   - Neither non-empty: no grant; last_grant is held.
//   - A grant pops the head and updates last_grant at the clock edge.
//  Write port (registered):
//   - On the edge after a grant: write_reg/write_data = popped entry.
//   - reg_write = 1 unless the popped reg == 0; a $zero entry is popped and dropped with reg_write = 0.
//   - No grant: reg_write = 0; write_reg/write_data hold their last values.
//  Latency: handshake in cycle t gives reg_write high in cycle t+2 at minimum, when the FIFO was empty and the port wins.
//  Throughput: 1 write per cycle combined; each port is guaranteed >= 1 write per 2 cycles under contention (RR).
//  Simultaneous push and pop on the same FIFO: both take effect; count is unchanged.
//  Ordering:
//   - Order within a port is preserved.
//   - Across ports, order = grant order; the block does not check for same-register hazards.
//  busy = (alu_count != 0) | (mem_count != 0) | reg_write.
// TESTING
//  1 Reset release, then one ALU push {reg=8, data=0x0000_00AA} at t
//    -> reg_write=1, write_reg=8, write_data=0xAA in t+2 only.
//  2 Both ports push continuously (ALU reg 9/0x11.., MEM reg 10/0x22..), RR_EN=1
//    -> writes alternate ALU, MEM, ALU, ... with ALU first; no entry lost.
//  3 Four back-to-back ALU pushes with DEPTH=2 while MEM is saturating
//    -> alu_ready drops when count=2; every accepted entry is written, in order.
//  4 MEM push {reg=0, data=0xDEAD_BEEF}
//    -> FIFO pops, reg_write stays 0, busy returns to 0.
//  5 Two entries queued, then rst_n pulsed low mid-cycle
//    -> outputs go to 0 immediately; no write occurs after release.
//  6 RR_EN=0, both ports saturated for 6 cycles -> all 6 writes come from the ALU; MEM waits.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Write-back bus: two queued requesters (ALU rd, load rt) in, one register-file write port out.
// Handshake: an entry transfers on a rising edge where valid && ready; ready depends only on FIFO occupancy.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              last_grant;
    logic              busy;

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready, reg_write, write_reg, write_data, last_grant, busy
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready, reg_write, write_reg, write_data, last_grant, busy
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two per-requester FIFOs feeding a round-robin / fixed-priority arbiter
// that drives a registered register-file write port.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int RR_EN      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_port_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int ALU   = 0;
    localparam int MEM   = 1;

    typedef logic [ENT_W-1:0] entry_t;

    entry_t            fifo_mem [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [2];
    logic [PTR_W-1:0]  rd_ptr   [2];
    logic [CNT_W-1:0]  count    [2];
    entry_t            in_entry [2];
    logic [1:0]        valid;
    logic [1:0]        ready;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        not_empty;
    logic              grant_any;
    logic              grant_mem;
    entry_t            head;
    logic              last_grant;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;

    assign valid         = {bus.mem_valid, bus.alu_valid};
    assign in_entry[ALU] = {bus.alu_reg, bus.alu_data};
    assign in_entry[MEM] = {bus.mem_reg, bus.mem_data};

    // Ready looks at the pre-pop count, so a full FIFO refuses even while it drains.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            not_empty[i] = (count[i] != '0);
            ready[i]     = rst_n && (count[i] != CNT_W'(FIFO_DEPTH));
        end
    end

    assign push = valid & ready;

    always_comb begin
        grant_any = 1'b1;
        grant_mem = 1'b0;
        if (not_empty == 2'b11) begin
            grant_mem = (RR_EN != 0) ? ~last_grant : 1'b0;
        end else if (not_empty[MEM]) begin
            grant_mem = 1'b1;
        end else if (!not_empty[ALU]) begin
            grant_any = 1'b0;
        end
        pop  = grant_any ? (grant_mem ? 2'b10 : 2'b01) : 2'b00;
        head = fifo_mem[grant_mem][rd_ptr[grant_mem]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr[i]] <= in_entry[i];
        end
    end

    // A $zero destination is popped normally but never enables the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            last_grant <= 1'b1;
        end else if (grant_any) begin
            reg_write  <= (head[ENT_W-1 -: ADDR_W] != '0);
            write_reg  <= head[ENT_W-1 -: ADDR_W];
            write_data <= head[DATA_W-1:0];
            last_grant <= grant_mem;
        end else begin
            reg_write  <= 1'b0;
        end
    end

    assign bus.alu_ready  = ready[ALU];
    assign bus.mem_ready  = ready[MEM];
    assign bus.reg_write  = reg_write;
    assign bus.write_reg  = write_reg;
    assign bus.write_data = write_data;
    assign bus.last_grant = last_grant;
    assign bus.busy       = (count[ALU] != '0) | (count[MEM] != '0) | reg_write;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: instance 0 round-robin, instance 1 fixed priority,
// checked every cycle against a queue-based model plus directed literal expectations.
module tb_wb_port_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int EW     = ADDR_W + DATA_W;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // stimulus driven into each instance
    logic              alu_valid_d [2] = '{1'b0, 1'b0};
    logic              mem_valid_d [2] = '{1'b0, 1'b0};
    logic [ADDR_W-1:0] alu_reg_d   [2] = '{'0, '0};
    logic [ADDR_W-1:0] mem_reg_d   [2] = '{'0, '0};
    logic [DATA_W-1:0] alu_data_d  [2] = '{'0, '0};
    logic [DATA_W-1:0] mem_data_d  [2] = '{'0, '0};
    logic [EW-1:0]     alu_send    [2][$];
    logic [EW-1:0]     mem_send    [2][$];
    logic              alu_acc     [2] = '{1'b0, 1'b0};
    logic              mem_acc     [2] = '{1'b0, 1'b0};
    int                wr_cnt      [2] = '{0, 0};
    int                alu_stall   [2] = '{0, 0};

    // observed DUT outputs
    logic              alu_ready_s [2];
    logic              mem_ready_s [2];
    logic              we_s        [2];
    logic              lg_s        [2];
    logic              busy_s      [2];
    logic [ADDR_W-1:0] wreg_s      [2];
    logic [DATA_W-1:0] wdata_s     [2];

    // scoreboard model state
    logic [EW-1:0]     alu_q  [2][$];
    logic [EW-1:0]     mem_q  [2][$];
    logic              m_we   [2] = '{1'b0, 1'b0};
    logic              m_last [2] = '{1'b1, 1'b1};
    logic [ADDR_W-1:0] m_reg  [2] = '{'0, '0};
    logic [DATA_W-1:0] m_data [2] = '{'0, '0};

    for (genvar g = 0; g < 2; g++) begin : u
        wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
        wb_port_arbiter #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .RR_EN(g == 0 ? 1 : 0)
        ) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus.slave)
        );
        assign bus.alu_valid  = alu_valid_d[g];
        assign bus.alu_reg    = alu_reg_d[g];
        assign bus.alu_data   = alu_data_d[g];
        assign bus.mem_valid  = mem_valid_d[g];
        assign bus.mem_reg    = mem_reg_d[g];
        assign bus.mem_data   = mem_data_d[g];
        assign alu_ready_s[g] = bus.alu_ready;
        assign mem_ready_s[g] = bus.mem_ready;
        assign we_s[g]        = bus.reg_write;
        assign lg_s[g]        = bus.last_grant;
        assign busy_s[g]      = bus.busy;
        assign wreg_s[g]      = bus.write_reg;
        assign wdata_s[g]     = bus.write_data;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
        end
    endtask

    // Model: one queue per requester; a grant takes the head of the chosen queue.
    always @(posedge clk or negedge rst_n) begin
        logic [EW-1:0] e;
        int            who;
        bit            a_acc;
        bit            m_acc;
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                alu_q[g].delete();
                mem_q[g].delete();
                m_we[g]   = 1'b0;
                m_reg[g]  = '0;
                m_data[g] = '0;
                m_last[g] = 1'b1;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                a_acc = alu_valid_d[g] && (alu_q[g].size() < DEPTH);
                m_acc = mem_valid_d[g] && (mem_q[g].size() < DEPTH);
                if (alu_q[g].size() != 0 && mem_q[g].size() != 0)
                    who = (g == 0) ? (m_last[g] ? 0 : 1) : 0;
                else if (alu_q[g].size() != 0)
                    who = 0;
                else if (mem_q[g].size() != 0)
                    who = 1;
                else
                    who = -1;
                if (who >= 0) begin
                    e         = (who == 0) ? alu_q[g].pop_front() : mem_q[g].pop_front();
                    m_reg[g]  = e[EW-1 -: ADDR_W];
                    m_data[g] = e[DATA_W-1:0];
                    m_we[g]   = (e[EW-1 -: ADDR_W] != 0);
                    m_last[g] = (who == 1);
                end else begin
                    m_we[g] = 1'b0;
                end
                if (a_acc) alu_q[g].push_back({alu_reg_d[g], alu_data_d[g]});
                if (m_acc) mem_q[g].push_back({mem_reg_d[g], mem_data_d[g]});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("d%0d_reg_write", g), 64'(we_s[g]), 64'(m_we[g]));
                chk($sformatf("d%0d_write_reg", g), 64'(wreg_s[g]), 64'(m_reg[g]));
                chk($sformatf("d%0d_write_data", g), 64'(wdata_s[g]), 64'(m_data[g]));
                chk($sformatf("d%0d_last_grant", g), 64'(lg_s[g]), 64'(m_last[g]));
                chk($sformatf("d%0d_alu_ready", g), 64'(alu_ready_s[g]),
                    64'(rst_n && (alu_q[g].size() < DEPTH)));
                chk($sformatf("d%0d_mem_ready", g), 64'(mem_ready_s[g]),
                    64'(rst_n && (mem_q[g].size() < DEPTH)));
                chk($sformatf("d%0d_busy", g), 64'(busy_s[g]),
                    64'((alu_q[g].size() != 0) || (mem_q[g].size() != 0) || m_we[g]));
            end
        end
    end

    // driver: one negedge per call; retire accepted items, present the next ones
    task automatic step();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            if (alu_valid_d[g] && alu_acc[g]) void'(alu_send[g].pop_front());
            if (mem_valid_d[g] && mem_acc[g]) void'(mem_send[g].pop_front());
            alu_valid_d[g] = (alu_send[g].size() != 0);
            mem_valid_d[g] = (mem_send[g].size() != 0);
            if (alu_valid_d[g]) {alu_reg_d[g], alu_data_d[g]} = alu_send[g][0];
            if (mem_valid_d[g]) {mem_reg_d[g], mem_data_d[g]} = mem_send[g][0];
            alu_acc[g] = alu_ready_s[g];
            mem_acc[g] = mem_ready_s[g];
            if (we_s[g]) wr_cnt[g]++;
            if (alu_valid_d[g] && !alu_ready_s[g]) alu_stall[g]++;
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        step();
        while ((alu_send[0].size() + alu_send[1].size() + mem_send[0].size() + mem_send[1].size() != 0
                || busy_s[0] || busy_s[1]) && n < 80) begin
            step();
            n++;
        end
        chk(nm, 64'(n < 80), 64'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        step();
        step();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_reg_write", 64'(we_s[0]), 64'(0));
        chk("rst_write_reg", 64'(wreg_s[0]), 64'(0));
        chk("rst_last_grant", 64'(lg_s[0]), 64'(1));
        chk("rst_alu_ready", 64'(alu_ready_s[0]), 64'(0));
        chk("rst_mem_ready", 64'(mem_ready_s[1]), 64'(0));
        rst_n = 1'b1;
        step();
        chk_en = 1'b1;

        // single ALU push: write appears exactly two cycles later
        alu_send[0].push_back({5'd8, 32'h0000_00AA});
        step();
        step();
        chk("t1_we_t1", 64'(we_s[0]), 64'(0));
        chk("t1_busy", 64'(busy_s[0]), 64'(1));
        step();
        chk("t1_we_t2", 64'(we_s[0]), 64'(1));
        chk("t1_reg", 64'(wreg_s[0]), 64'(8));
        chk("t1_data", 64'(wdata_s[0]), 64'h0000_00AA);
        step();
        chk("t1_we_t3", 64'(we_s[0]), 64'(0));
        chk("t1_idle", 64'(busy_s[0]), 64'(0));

        // both ports streaming under round robin
        do_reset();
        for (int k = 0; k < 6; k++) begin
            alu_send[0].push_back({5'd9, 32'h1100_0000 + 32'(k)});
            mem_send[0].push_back({5'd10, 32'h2200_0000 + 32'(k)});
        end
        wr_cnt[0] = 0;
        step();
        step();
        chk("t2_we_first", 64'(we_s[0]), 64'(0));
        step();
        chk("t2_w0_reg", 64'(wreg_s[0]), 64'(9));
        chk("t2_w0_data", 64'(wdata_s[0]), 64'h1100_0000);
        step();
        chk("t2_w1_reg", 64'(wreg_s[0]), 64'(10));
        chk("t2_w1_data", 64'(wdata_s[0]), 64'h2200_0000);
        step();
        chk("t2_w2_reg", 64'(wreg_s[0]), 64'(9));
        chk("t2_w2_data", 64'(wdata_s[0]), 64'h1100_0001);
        step();
        chk("t2_w3_reg", 64'(wreg_s[0]), 64'(10));
        chk("t2_w3_data", 64'(wdata_s[0]), 64'h2200_0001);
        drain("t2_drain");
        chk("t2_writes", 64'(wr_cnt[0]), 64'(12));

        // ALU back-pressure while MEM saturates
        wr_cnt[0] = 0;
        alu_stall[0] = 0;
        for (int k = 0; k < 4; k++) alu_send[0].push_back({5'd11 + 5'(k), 32'h3300_0000 + 32'(k)});
        for (int k = 0; k < 8; k++) mem_send[0].push_back({5'd15, 32'h5A00_0000 + 32'(k)});
        drain("t3_drain");
        chk("t3_backpressure", 64'(alu_stall[0] != 0), 64'(1));
        chk("t3_writes", 64'(wr_cnt[0]), 64'(12));

        // $zero destination is dropped
        wr_cnt[0] = 0;
        mem_send[0].push_back({5'd0, 32'hDEAD_BEEF});
        step();
        step();
        chk("t4_busy_q", 64'(busy_s[0]), 64'(1));
        chk("t4_we_q", 64'(we_s[0]), 64'(0));
        step();
        chk("t4_we_pop", 64'(we_s[0]), 64'(0));
        chk("t4_busy_end", 64'(busy_s[0]), 64'(0));
        chk("t4_data", 64'(wdata_s[0]), 64'hDEAD_BEEF);
        chk("t4_last", 64'(lg_s[0]), 64'(1));
        chk("t4_writes", 64'(wr_cnt[0]), 64'(0));

        // mid-cycle reset with entries queued
        alu_send[0].push_back({5'd3, 32'h0000_0055});
        mem_send[0].push_back({5'd4, 32'h0000_0066});
        step();
        step();
        step();
        chk("t5_pre_we", 64'(we_s[0]), 64'(1));
        chk("t5_pre_reg", 64'(wreg_s[0]), 64'(3));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 64'(we_s[0]), 64'(0));
        chk("t5_rst_reg", 64'(wreg_s[0]), 64'(0));
        chk("t5_rst_data", 64'(wdata_s[0]), 64'(0));
        chk("t5_rst_busy", 64'(busy_s[0]), 64'(0));
        chk("t5_rst_ready", 64'(alu_ready_s[0]), 64'(0));
        chk("t5_rst_last", 64'(lg_s[0]), 64'(1));
        #1 rst_n = 1'b1;
        wr_cnt[0] = 0;
        repeat (4) step();
        chk("t5_no_write", 64'(wr_cnt[0]), 64'(0));

        // fixed priority: ALU owns the port while it has entries
        wr_cnt[1] = 0;
        for (int k = 0; k < 8; k++) begin
            alu_send[1].push_back({5'd16, 32'h4400_0000 + 32'(k)});
            mem_send[1].push_back({5'd17, 32'h5500_0000 + 32'(k)});
        end
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t6_we_%0d", i), 64'(we_s[1]), 64'(1));
            chk($sformatf("t6_reg_%0d", i), 64'(wreg_s[1]), 64'(16));
        end
        drain("t6_drain");
        chk("t6_writes", 64'(wr_cnt[1]), 64'(16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
